nebula_inject_arbiter: RTL and testbench
========================================

# nebula_inject_arbiter

Packet-atomic round-robin arbiter that shares one router local injection port among NUM_REQ requesters (for example a core, a DMA engine and a test traffic generator). It sits in front of a node's nebula_router local request port. Each requester has a token-bucket injection-rate limiter, and per-requester packet counters are kept for statistics. The output is a registered single-entry stage, so the router sees a registered valid/data pair.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- FLIT_W, 64: flit width in bits.
- RATE_PERIOD, 16: cycles between token refills (≥2).
- BUCKET_MAX, 4: token bucket depth per requester (≥1).
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_data  in  NUM_REQ×FLIT_W  per-requester flit.
- req_last  in  NUM_REQ  flit is the packet tail; a 1-flit packet has last=1.
- req_ready  out  NUM_REQ  flit accepted this cycle when valid&ready.
- out_valid  out  1  flit valid toward the router.
- out_data  out  FLIT_W  flit toward the router.
- out_last  out  1  tail marker toward the router.
- out_ready  in  1  router local_req_ready.
- cfg_rate_en  in  1  1 = token throttling enforced.
- pkt_count  out  NUM_REQ×16  packets (tail flits) accepted per requester, saturating at 0xFFFF.
- busy  out  1  state==LOCKED or out_valid.

## Operation
- **Output stage.** load_en = !out_valid || out_ready. At most one flit is accepted per cycle. req_ready[i] = (i is granted) && load_en && rst_n. out_valid/out_data/out_last hold stable until out_ready.
- **FSM states.** IDLE and LOCKED. Registers: owner and rr_ptr.
- **IDLE.**
  - eligible[i] = req_valid[i] && (!cfg_rate_en || tokens[i]!=0).
  - Grant goes to the first eligible index searching rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - On acceptance of a flit from g with last=1: stay IDLE, rr_ptr←(g+1) mod NUM_REQ.
  - On acceptance with last=0: go to LOCKED, owner←g.
- **LOCKED.**
  - Only the owner is granted. Tokens are not checked.
  - If the owner drops req_valid, the lock is held and bubbles are emitted.
  - When the tail is accepted: go to IDLE, rr_ptr←(owner+1) mod NUM_REQ.
- **Tokens.**
  - One token is consumed per packet, at head acceptance, only when cfg_rate_en=1.
  - A period counter runs 0..RATE_PERIOD-1 and wraps. On the wrap cycle (count==RATE_PERIOD-1), every bucket refills by 1.
  - tokens_next = min(tokens − consume + refill, BUCKET_MAX). Simultaneous consume and refill at BUCKET_MAX leaves BUCKET_MAX.
  - Refill runs regardless of cfg_rate_en. A cfg_rate_en change takes effect at the next head arbitration.
- **pkt_count[i].** Incremented on each tail acceptance from i. Holds at 0xFFFF once saturated.
- **Requester rules.** req_valid must not depend on req_ready. req_data/req_last are held stable while valid and not ready.

## Timing
- Latency: 1 cycle from req_valid&req_ready to out_valid.
- Throughput: 1 flit/cycle with out_ready=1, including back-to-back packets from different requesters (no arbitration bubble).
- **Reset values** (after the edge with rst_n=0):
  - out_valid=0, out_data=0, out_last=0.
  - state=IDLE, rr_ptr=0, owner=0.
  - tokens=BUCKET_MAX, period counter=0, pkt_count=0, busy=0.
  - req_ready=0 combinationally while rst_n=0.
- **Reset mid-packet:** the in-flight flit and the lock are discarded. Arbitration restarts at requester 0.
- **Backpressure:** with out_ready=0 and out_valid=1, all req_ready=0 and state/tokens/rr_ptr are frozen. The refill counter still runs.
- **Empty:** no eligible requester gives no grant and no state change. out_valid clears after the pending flit drains.

## Test plan
- **Basic transfer.** Reset 10 cycles, then req0 sends 1-flit packet data=0xA5, last=1, out_ready=1. Required: out_valid=1 with 0xA5/last=1 the next cycle, pkt_count[0]=1, busy=0 one cycle after drain.
- **Fairness.** All four requesters continuously valid with 1-flit packets, rate disabled, out_ready=1, 40 cycles. Required: grant order 0,1,2,3,0,…; out_valid high every cycle after the first; each pkt_count=10.
- **Packet atomicity.** req1 sends a 3-flit packet (0x11,0x12,0x13 last) while req0 and req2 hold 1-flit packets. Required: out shows 0x11,0x12,0x13 contiguously, then req2, then req0.
- **Backpressure.** out_ready=0 for 5 cycles while out_valid=1. Required: out_data stable and req_ready all 0 for those 5 cycles; after release the sequence continues with no loss or duplication.
- **Rate limit.** cfg_rate_en=1, RATE_PERIOD=16, BUCKET_MAX=2, req0 always valid with 1-flit packets. Required: 2 packets on consecutive cycles, then exactly one per 16 cycles. A refill coinciding with a consume leaves tokens unchanged.
- **Reset mid-packet.** Assert rst_n=0 for 1 cycle after flit 2 of a 4-flit packet from req3. Required: all outputs at reset values the next cycle; after release, req0 (if valid) wins the first grant.

Source files
------------

// File: rtl/nebula_inject_arbiter.sv
// Packet-atomic round-robin arbiter feeding one router local injection port, with per-requester token-bucket rate limiting.
// Latency: 1 cycle from req_valid&req_ready to out_valid; 1 flit/cycle sustained, no bubble between packets.
// Backpressure: out_ready=0 with out_valid=1 drops every req_ready and freezes lock/rr_ptr/tokens; the refill period counter keeps running.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/data/last      per-requester flit stream (data packed NUM_REQ x FLIT_W, requester i at [i*FLIT_W +: FLIT_W])
//   req_ready                per-requester accept strobe (valid&ready = flit taken)
//   out_valid/data/last      registered single-entry output toward the router, held until out_ready
//   out_ready                router local_req_ready
//   cfg_rate_en              1 = token throttling enforced at head arbitration
//   pkt_count                per-requester saturating tail-flit counters (requester i at [i*16 +: 16])
//   busy                     a packet is locked in progress or a flit is pending at the output
module nebula_inject_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FLIT_W      = 64,
    parameter int RATE_PERIOD = 16,
    parameter int BUCKET_MAX  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*FLIT_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [FLIT_W-1:0]         out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    input  logic                      cfg_rate_en,
    output logic [NUM_REQ*16-1:0]     pkt_count,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TOK_W = $clog2(BUCKET_MAX + 1);
    localparam int CNT_W = $clog2(RATE_PERIOD);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [TOK_W-1:0] TOK_MAX   = TOK_W'(BUCKET_MAX);
    localparam logic [TOK_W:0]   TOK_MAX_W = (TOK_W + 1)'(BUCKET_MAX);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(RATE_PERIOD - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   period_cnt;
    logic [TOK_W-1:0]   tokens    [NUM_REQ];
    logic [15:0]        pkt_cnt_q [NUM_REQ];

    logic               load_en;
    logic [NUM_REQ-1:0] eligible;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic               acc_valid;
    logic               acc_last;
    logic [FLIT_W-1:0]  acc_dat;
    logic               accept;
    logic               refill;
    logic [NUM_REQ-1:0] consume;
    logic [TOK_W:0]     tok_sum   [NUM_REQ];
    logic [TOK_W-1:0]   tok_next  [NUM_REQ];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // The output register can take a new flit when empty or draining this cycle.
    assign load_en = !out_valid || out_ready;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (!cfg_rate_en || (tokens[i] != '0));
        end
    end

    // While locked the owner keeps the grant even when it idles, so its
    // packet cannot be interleaved; idle cycles simply become bubbles.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state == LOCKED) begin
            grant_vld = 1'b1;
            grant_idx = owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_vld && eligible[IDX_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
                    grant_vld = 1'b1;
                    grant_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                end
            end
        end
    end

    assign acc_valid = req_valid[grant_idx];
    assign acc_last  = req_last[grant_idx];
    assign acc_dat   = req_data[int'(grant_idx)*FLIT_W +: FLIT_W];
    assign accept    = grant_vld && acc_valid && load_en;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n && load_en && grant_vld && (grant_idx == IDX_W'(i));
        end
    end

    // A token is spent only on a head flit, which is always taken in IDLE.
    assign refill = (period_cnt == PER_LAST);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            consume[i]  = accept && (state == IDLE) && cfg_rate_en && (grant_idx == IDX_W'(i));
            tok_sum[i]  = {1'b0, tokens[i]} + {{TOK_W{1'b0}}, refill} - {{TOK_W{1'b0}}, consume[i]};
            tok_next[i] = (tok_sum[i] > TOK_MAX_W) ? TOK_MAX : tok_sum[i][TOK_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            period_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                tokens[i]    <= TOK_MAX;
                pkt_cnt_q[i] <= '0;
            end
        end else begin
            period_cnt <= refill ? '0 : period_cnt + 1'b1;

            // Buckets freeze along with arbitration while the output is stalled;
            // a refill that lands inside a stall is dropped.
            if (load_en) begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= acc_dat;
                    out_last <= acc_last;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    tokens[i] <= tok_next[i];
                end
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (acc_last) begin
                            rr_ptr <= next_idx(grant_idx);
                        end else begin
                            state <= LOCKED;
                            owner <= grant_idx;
                        end
                    end
                    LOCKED: begin
                        if (acc_last) begin
                            state  <= IDLE;
                            rr_ptr <= next_idx(owner);
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (acc_last && (pkt_cnt_q[grant_idx] != 16'hFFFF)) begin
                    pkt_cnt_q[grant_idx] <= pkt_cnt_q[grant_idx] + 16'd1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
            assign pkt_count[gi*16 +: 16] = pkt_cnt_q[gi];
        end
    endgenerate

    assign busy = (state == LOCKED) || out_valid;

endmodule

// File: tb/tb_nebula_inject_arbiter.sv
// Self-checking bench for nebula_inject_arbiter: directed vector table, hand-written
// corner sequences (fairness, rate limit, reset mid-packet) and randomized traffic
// compared every cycle against a packet-level reference model.
module tb_nebula_inject_arbiter;

    localparam int NR = 4;
    localparam int RP = 16;
    localparam int BM = 2;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      vld;
    logic [NR-1:0][63:0] dat;
    logic [NR-1:0]      lst;
    logic [NR-1:0]      req_ready;
    logic               out_valid;
    logic [63:0]        out_data;
    logic               out_last;
    logic               out_ready;
    logic               rate;
    logic [NR-1:0][15:0] pkt_count;
    logic               busy;

    nebula_inject_arbiter #(
        .NUM_REQ    (NR),
        .FLIT_W     (64),
        .RATE_PERIOD(RP),
        .BUCKET_MAX (BM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (vld),
        .req_data   (dat),
        .req_last   (lst),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .cfg_rate_en(rate),
        .pkt_count  (pkt_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_locked;
    int          m_owner;
    int          m_rr;
    int          m_per;
    int          m_tok [NR];
    int          m_cnt [NR];
    bit          m_ov;
    bit          m_ol;
    logic [63:0] m_od;
    logic [NR-1:0] m_acc;
    logic [NR-1:0] rdy_seen;

    // Who holds the grant this cycle: the packet owner, else the first requester
    // at or after the round-robin pointer that is valid and (if throttled) has a token.
    function automatic int m_grant();
        if (m_locked) return m_owner;
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (m_rr + k) % NR;
            if (vld[j] && (!rate || m_tok[j] > 0)) return j;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        bit load;
        bit acc;
        bit refill;
        m_acc = '0;
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_rr = 0; m_per = 0;
            m_ov = 0; m_ol = 0; m_od = 64'h0;
            for (int i = 0; i < NR; i++) begin
                m_tok[i] = BM;
                m_cnt[i] = 0;
            end
            return;
        end
        load = !m_ov || out_ready;
        g    = m_grant();
        acc  = 0;
        if (g >= 0) acc = load && vld[g];
        refill = (m_per == RP - 1);
        m_per  = (m_per + 1) % RP;
        if (load) begin
            for (int i = 0; i < NR; i++) begin
                int t;
                t = m_tok[i] + (refill ? 1 : 0);
                if (acc && !m_locked && g == i && rate) t = t - 1;
                m_tok[i] = (t > BM) ? BM : t;
            end
            m_ov = acc;
            if (acc) begin
                m_od = dat[g];
                m_ol = lst[g];
            end
        end
        if (acc) begin
            m_acc[g] = 1'b1;
            if (lst[g]) begin
                if (m_cnt[g] < 65535) m_cnt[g]++;
                m_locked = 0;
                m_rr     = (g + 1) % NR;
            end else begin
                m_locked = 1;
                m_owner  = g;
            end
        end
    endtask

    // One clock: check req_ready against the model before the edge, advance the
    // model at the edge, then check the registered outputs just after it.
    task automatic tick();
        int g;
        logic [NR-1:0] er;
        #1;
        g  = m_grant();
        er = '0;
        if (rst_n && (!m_ov || out_ready) && g >= 0) er[g] = 1'b1;
        rdy_seen = req_ready;
        chk("req_ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_last", 64'(out_last), 64'(m_ol));
        end
        chk("busy", 64'(busy), 64'(m_locked || m_ov));
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("pkt_count%0d", i), 64'(pkt_count[i]), 64'(m_cnt[i]));
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit           rst;
        bit [3:0]     v;
        bit [3:0]     l;
        bit [3:0][7:0] d;
        bit           ordy;
        bit [3:0]     e_rdy;
        bit           e_ov;
        bit [7:0]     e_d;
        bit           e_l;
    } vec_t;

    vec_t tbl[16];

    int          src_rem [NR];
    int          c_abs;

    initial begin
        // basic transfer
        tbl[0]  = '{1, 4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'hA5}, 1, 4'b0001, 1, 8'hA5, 1};
        tbl[1]  = '{1, 4'b0000, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}, 1, 4'b0000, 0, 8'h00, 0};
        // packet atomicity: req1 3-flit vs req0/req2 single flits, rr_ptr at 1
        tbl[2]  = '{1, 4'b0111, 4'b0101, {8'h00, 8'h21, 8'h11, 8'h01}, 1, 4'b0010, 1, 8'h11, 0};
        tbl[3]  = '{1, 4'b0111, 4'b0101, {8'h00, 8'h21, 8'h12, 8'h01}, 1, 4'b0010, 1, 8'h12, 0};
        tbl[4]  = '{1, 4'b0111, 4'b0111, {8'h00, 8'h21, 8'h13, 8'h01}, 1, 4'b0010, 1, 8'h13, 1};
        tbl[5]  = '{1, 4'b0101, 4'b0101, {8'h00, 8'h21, 8'h00, 8'h01}, 1, 4'b0100, 1, 8'h21, 1};
        tbl[6]  = '{1, 4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h01}, 1, 4'b0001, 1, 8'h01, 1};
        // backpressure for 5 cycles: output holds 0x01, no grants
        for (int r = 7; r < 12; r++)
            tbl[r] = '{1, 4'b1100, 4'b1100, {8'h31, 8'h22, 8'h00, 8'h00}, 0, 4'b0000, 1, 8'h01, 1};
        tbl[12] = '{1, 4'b1100, 4'b1100, {8'h31, 8'h22, 8'h00, 8'h00}, 1, 4'b0100, 1, 8'h22, 1};
        tbl[13] = '{1, 4'b1000, 4'b1000, {8'h31, 8'h00, 8'h00, 8'h00}, 1, 4'b1000, 1, 8'h31, 1};
        tbl[14] = '{1, 4'b0000, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}, 1, 4'b0000, 0, 8'h00, 0};
        // reset cycle: ready forced low, outputs cleared
        tbl[15] = '{0, 4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'hA5}, 1, 4'b0000, 0, 8'h00, 0};

        rst_n = 1'b0; vld = '0; lst = '0; dat = '0; out_ready = 1'b1; rate = 1'b0;
        m_ov = 0; m_locked = 0; m_rr = 0; m_owner = 0; m_per = 0; m_ol = 0; m_od = '0;
        for (int i = 0; i < NR; i++) begin m_tok[i] = BM; m_cnt[i] = 0; src_rem[i] = 0; end

        // reset for 10 cycles, then reset-state checks
        for (int k = 0; k < 10; k++) tick();
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_last", 64'(out_last), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_pkt_count", 64'(pkt_count), 64'h0);
        chk("rst_req_ready", 64'(rdy_seen), 64'h0);

        for (int r = 0; r < 16; r++) begin
            rst_n     = tbl[r].rst;
            vld       = tbl[r].v;
            lst       = tbl[r].l;
            out_ready = tbl[r].ordy;
            for (int i = 0; i < NR; i++) dat[i] = {56'h0, tbl[r].d[i]};
            tick();
            chk($sformatf("tbl%0d_ready", r), 64'(rdy_seen), 64'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d_valid", r), 64'(out_valid), 64'(tbl[r].e_ov));
            if (tbl[r].e_ov || !tbl[r].rst) begin
                chk($sformatf("tbl%0d_data", r), out_data, {56'h0, tbl[r].e_d});
                chk($sformatf("tbl%0d_last", r), 64'(out_last), 64'(tbl[r].e_l));
            end
            if (r == 1) chk("basic_pkt_count0", 64'(pkt_count[0]), 64'd1);
        end

        // fairness: 4 requesters, 1-flit packets, 40 cycles after the reset in row 15
        rst_n = 1'b1; out_ready = 1'b1; rate = 1'b0;
        vld = 4'b1111; lst = 4'b1111;
        for (int i = 0; i < NR; i++) dat[i] = 64'(8'hF0 + i);
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("fair_valid", 64'(out_valid), 64'h1);
            chk("fair_order", out_data, 64'(8'hF0 + (c % NR)));
        end
        for (int i = 0; i < NR; i++) chk($sformatf("fair_count%0d", i), 64'(pkt_count[i]), 64'd10);

        // rate limit: bucket of 2, refill every 16 cycles
        rst_n = 1'b0; vld = '0; tick();
        rst_n = 1'b1; rate = 1'b1; vld = 4'b0001; lst = 4'b0001; dat[0] = 64'h77;
        for (c_abs = 0; c_abs < 64; c_abs++) begin
            tick();
            chk($sformatf("rate_c%0d", c_abs), 64'(out_valid),
                64'((c_abs < 2) || (c_abs % RP == 0)));
        end
        // let the bucket fill, then request exactly on a refill cycle: the
        // coinciding consume+refill keeps the bucket full, giving 3 in a row
        vld = 4'b0000;
        for (; c_abs < 111; c_abs++) tick();
        vld = 4'b0001;
        for (; c_abs < 119; c_abs++) begin
            tick();
            chk($sformatf("refill_c%0d", c_abs), 64'(out_valid), 64'(c_abs <= 113));
        end

        // reset mid-packet: req2 moves rr_ptr to 3, req3 starts 4-flit packet
        rst_n = 1'b0; vld = '0; rate = 1'b0; tick();
        rst_n = 1'b1;
        vld = 4'b0100; lst = 4'b0100; dat[2] = 64'h2A; tick();
        vld = 4'b1000; lst = 4'b0000; dat[3] = 64'h31; tick();
        dat[3] = 64'h32; tick();
        chk("mid_flit2", out_data, 64'h32);
        rst_n = 1'b0; vld = 4'b1001; lst = 4'b0001; dat[0] = 64'h0A; dat[3] = 64'h33;
        tick();
        chk("mid_rst_ready", 64'(rdy_seen), 64'h0);
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_data", out_data, 64'h0);
        chk("mid_rst_last", 64'(out_last), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_count2", 64'(pkt_count[2]), 64'h0);
        rst_n = 1'b1;
        tick();
        chk("mid_after_ready", 64'(rdy_seen), 64'h1);
        chk("mid_after_data", out_data, 64'h0A);

        // randomized traffic against the model
        rst_n = 1'b0; vld = '0; tick();
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) src_rem[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) rate = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            rst_n     = ($urandom_range(0, 599) != 0);
            tick();
            for (int i = 0; i < NR; i++) begin
                if (m_acc[i]) begin
                    vld[i] = 1'b0;
                    src_rem[i]--;
                end
                if (!vld[i] && $urandom_range(0, 3) != 0) begin
                    if (src_rem[i] <= 0) src_rem[i] = $urandom_range(1, 4);
                    vld[i] = 1'b1;
                    dat[i] = {$urandom, $urandom};
                    lst[i] = (src_rem[i] == 1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
